serial_sequence_generator: RTL and testbench
============================================

Name: serial_sequence_generator

Overview:
- Transmit-side companion to the serial sequence detector.
- Accepts a parallel data word and shifts it out MSB-first on one serial line.
- Optionally prepends a fixed 3-bit sync pattern, which the detector recognises downstream.
- Produces the stimulus stream for the detector in system and bench use. Provides busy/done handshaking for gapless back-to-back frames.

Parameters:
- DATA_W, 8, width of the parallel payload word (legal 1..32).
- PATTERN, 3'b101, 3-bit sync pattern, sent MSB first.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  request to start a frame; sampled on rising edge.
- din  input  DATA_W  payload word; captured in the accepting cycle.
- with_pat  input  1  captured with din; 1 = prepend PATTERN.
- so  output  1  serial output bit.
- busy  output  1  high while a frame is being shifted out.
- done  output  1  one-cycle pulse while the last bit of a frame is on so.
- bit_idx  output  6  index of the bit currently on so within the frame (0 = first bit); 0 when idle.

Behaviour:
- Reset (rst=1 at an edge): next cycle so=0, busy=0, done=0, bit_idx=0, state=IDLE, shift register cleared.
  - rst overrides load.
  - Reset mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: so=0, busy=0.
  - PRE: shifting the 3 pattern bits.
  - DATA: shifting the DATA_W payload bits.
- Accept condition: load=1 && (state==IDLE || done==1). Otherwise load is ignored (no queueing) and din/with_pat are not captured.
- On accept at edge t:
  - din and with_pat are registered.
  - From cycle t+1, so carries the first frame bit.
  - with_pat=1: PRE for 3 cycles (PATTERN[2], [1], [0]), then DATA for DATA_W cycles (din[DATA_W-1] down to din[0]).
  - with_pat=0: go straight to DATA.
- Frame length L = DATA_W + 3·with_pat cycles. busy=1 for exactly L consecutive cycles.
- bit_idx increments 0..L-1, one per cycle.
- done=1 only in the cycle where bit_idx==L-1.
- End of frame:
  - No accept in the done cycle: next cycle returns to IDLE (so=0, busy=0).
  - Accept in the done cycle: new frame's first bit appears the very next cycle, with busy held high and no idle gap.
- so is registered: driven from the MSB of the internal shift register, no combinational path from inputs.
- Input changes while busy have no effect on the frame in flight.
- DATA_W=1 with with_pat=0: L=1, so busy and done are both high for the single cycle.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with load=1 and din=8'hFF -> so=0, busy=0, done=0, bit_idx=0 throughout and on the first cycle after release.
2. Frame with pattern: load=1 with din=8'hA5, with_pat=1 for one cycle.
   - so over the next 11 cycles = 1,0,1,1,0,1,0,0,1,0,1.
   - busy high for exactly 11 cycles; done only on the 11th; bit_idx 0..10.
   - Detector fed from so asserts detected after the third bit.
3. Frame without pattern: din=8'h3C, with_pat=0 -> so = 0,0,1,1,1,1,0,0 over 8 cycles; busy high 8 cycles; done on the 8th; then so=0, busy=0.
4. Load while busy: start din=8'hF0, then pulse load with din=8'h0F in the 4th busy cycle -> second request ignored; output is exactly F0's bits; IDLE afterwards.
5. Back-to-back: first din=8'h81 with_pat=0; hold load=1 with din=8'h7E during its done cycle.
   - so over 16 contiguous cycles = 1,0,0,0,0,0,0,1,0,1,1,1,1,1,1,0.
   - busy never drops; done pulses at cycles 8 and 16.
6. Reset mid-frame: assert rst in the 5th cycle of a with_pat=1 frame -> next cycle so=0, busy=0, no done pulse; a subsequent load starts a clean frame at bit_idx=0 with PATTERN first.

Source files
------------

// File: rtl/serial_sequence_generator.sv
// rtl/serial_sequence_generator.sv - serialises a payload word MSB-first with an optional 3-bit sync pattern
//
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (overrides load)
//   load     : frame start request, honoured when idle or in the done cycle
//   din      : payload word, captured on accept
//   with_pat : captured with din; 1 prepends PATTERN to the frame
//   so       : registered serial output bit
//   busy     : high for every cycle a frame bit is on so
//   done     : high while the last bit of a frame is on so
//   bit_idx  : position of the current bit within the frame, 0 when idle
module serial_sequence_generator #(
  parameter int         DATA_W  = 8,
  parameter logic [2:0] PATTERN = 3'b101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              with_pat,
  output logic              so,
  output logic              busy,
  output logic              done,
  output logic [5:0]        bit_idx
);

  localparam int         SW         = DATA_W + 3;
  localparam logic [5:0] LAST_NOPAT = 6'(DATA_W - 1);
  localparam logic [5:0] LAST_PAT   = 6'(DATA_W + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_shift;
  logic [5:0]    r_idx;
  logic [5:0]    r_last;
  logic          w_done;
  logic          w_accept;

  // The done cycle doubles as an accept window so frames can run gapless.
  always_comb begin
    w_done   = (r_state != S_IDLE) && (r_idx == r_last);
    w_accept = load && ((r_state == S_IDLE) || w_done);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = with_pat ? S_PRE : S_DATA;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_PRE:   if (r_idx == 6'd2) w_state_nxt = S_DATA;
        S_DATA:  if (w_done) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The whole frame is preloaded left-justified so the MSB is always the
  // bit on the line; without a pattern the three spare LSBs are just fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_shift <= with_pat ? {PATTERN, din} : {din, 3'b000};
        r_idx   <= '0;
        r_last  <= with_pat ? LAST_PAT : LAST_NOPAT;
      end else if (w_done) begin
        // Clearing here keeps so low once the line goes idle.
        r_shift <= '0;
        r_idx   <= '0;
      end else if (r_state != S_IDLE) begin
        r_shift <= {r_shift[SW-2:0], 1'b0};
        r_idx   <= r_idx + 6'd1;
      end
    end
  end

  always_comb begin
    so      = r_shift[SW-1];
    busy    = (r_state != S_IDLE);
    done    = w_done;
    bit_idx = r_idx;
  end

endmodule

// File: tb/tb_serial_sequence_generator.sv
// tb/tb_serial_sequence_generator.sv - directed self-checking bench for serial_sequence_generator
module tb_serial_sequence_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       with_pat;
  logic       so;
  logic       busy;
  logic       done;
  logic [5:0] bit_idx;

  logic       load1;
  logic [0:0] din1;
  logic       wp1;
  logic       so1;
  logic       busy1;
  logic       done1;
  logic [5:0] idx1;

  int checks = 0;
  int errors = 0;

  serial_sequence_generator #(.DATA_W(8), .PATTERN(3'b101)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .with_pat (with_pat),
    .so       (so),
    .busy     (busy),
    .done     (done),
    .bit_idx  (bit_idx)
  );

  serial_sequence_generator #(.DATA_W(1), .PATTERN(3'b101)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load1),
    .din      (din1),
    .with_pat (wp1),
    .so       (so1),
    .busy     (busy1),
    .done     (done1),
    .bit_idx  (idx1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_so, input logic e_busy, input logic e_done,
                         input logic [5:0] e_idx);
    chk(tag, "so", 32'(so), 32'(e_so));
    chk(tag, "busy", 32'(busy), 32'(e_busy));
    chk(tag, "done", 32'(done), 32'(e_done));
    chk(tag, "bit_idx", 32'(bit_idx), 32'(e_idx));
  endtask

  // Checks a whole frame starting at the current cycle (first bit already on so).
  // At cycle inj, a new request is presented; it is withdrawn one cycle later
  // unless inj is the last cycle, in which case the caller withdraws it.
  task automatic frame_check(input string tag, input logic [63:0] bits, input int len,
                             input int inj, input logic [7:0] inj_din, input logic inj_wp);
    for (int i = 0; i < len; i++) begin
      if (i != 0) tick();
      if (i == inj + 1) load = 1'b0;
      chk_out($sformatf("%s[%0d]", tag, i), bits[len-1-i], 1'b1, (i == len - 1), 6'(i));
      if (i == inj) begin
        load     = 1'b1;
        din      = inj_din;
        with_pat = inj_wp;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; din = 8'hFF; with_pat = 1'b1;
    load1 = 1'b0; din1 = 1'b0; wp1 = 1'b0;

    // Reset dominates a pending load.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("reset[%0d]", i), 1'b0, 1'b0, 1'b0, 6'd0);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    chk_out("post_reset", 1'b0, 1'b0, 1'b0, 6'd0);

    // Frame with pattern: 101 then A5.
    load = 1'b1; din = 8'hA5; with_pat = 1'b1;
    tick();
    load = 1'b0; din = 8'h00; with_pat = 1'b0;
    frame_check("pat_a5", 64'b101_1010_0101, 11, -5, 8'h00, 1'b0);
    tick();
    chk_out("pat_a5_idle", 1'b0, 1'b0, 1'b0, 6'd0);

    // Frame without pattern.
    load = 1'b1; din = 8'h3C; with_pat = 1'b0;
    tick();
    load = 1'b0;
    frame_check("nopat_3c", 64'h3C, 8, -5, 8'h00, 1'b0);
    tick();
    chk_out("nopat_3c_idle", 1'b0, 1'b0, 1'b0, 6'd0);

    // Load during the 4th busy cycle is ignored, including its with_pat.
    load = 1'b1; din = 8'hF0; with_pat = 1'b0;
    tick();
    load = 1'b0;
    frame_check("busy_f0", 64'hF0, 8, 3, 8'h0F, 1'b1);
    tick();
    chk_out("busy_f0_idle", 1'b0, 1'b0, 1'b0, 6'd0);

    // Back-to-back: second request presented in the done cycle.
    load = 1'b1; din = 8'h81; with_pat = 1'b0;
    tick();
    load = 1'b0;
    frame_check("b2b_81", 64'h81, 8, 7, 8'h7E, 1'b0);
    tick();
    load = 1'b0;
    frame_check("b2b_7e", 64'h7E, 8, -5, 8'h00, 1'b0);
    tick();
    chk_out("b2b_idle", 1'b0, 1'b0, 1'b0, 6'd0);

    // Reset in the 5th cycle of a patterned frame.
    load = 1'b1; din = 8'hA5; with_pat = 1'b1;
    tick();
    load = 1'b0;
    chk_out("abort[0]", 1'b1, 1'b1, 1'b0, 6'd0);
    tick(); chk_out("abort[1]", 1'b0, 1'b1, 1'b0, 6'd1);
    tick(); chk_out("abort[2]", 1'b1, 1'b1, 1'b0, 6'd2);
    tick(); chk_out("abort[3]", 1'b1, 1'b1, 1'b0, 6'd3);
    tick(); chk_out("abort[4]", 1'b0, 1'b1, 1'b0, 6'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("abort_rst", 1'b0, 1'b0, 1'b0, 6'd0);
    tick();
    chk_out("abort_quiet", 1'b0, 1'b0, 1'b0, 6'd0);
    load = 1'b1; din = 8'h3C; with_pat = 1'b1;
    tick();
    load = 1'b0;
    frame_check("restart", 64'b101_0011_1100, 11, -5, 8'h00, 1'b0);
    tick();
    chk_out("restart_idle", 1'b0, 1'b0, 1'b0, 6'd0);

    // DATA_W=1 without pattern: a single-cycle frame, busy and done together.
    load1 = 1'b1; din1 = 1'b1; wp1 = 1'b0;
    tick();
    load1 = 1'b0;
    chk("w1", "so", 32'(so1), 32'd1);
    chk("w1", "busy", 32'(busy1), 32'd1);
    chk("w1", "done", 32'(done1), 32'd1);
    chk("w1", "bit_idx", 32'(idx1), 32'd0);
    tick();
    chk("w1_idle", "so", 32'(so1), 32'd0);
    chk("w1_idle", "busy", 32'(busy1), 32'd0);
    chk("w1_idle", "done", 32'(done1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
